systolic_array_sequencer: RTL and testbench

//  Job sequencer between the AXI-Stream DMA ports, the A/B input buffers and the 3x3 systolic array.

---
 rtl/systolic_array_sequencer_if.sv | 31 +++
 rtl/systolic_array_sequencer.sv | 147 ++++++++++++++
 tb/tb_systolic_array_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_sequencer_if.sv
// Handshake bundle between the job sequencer, the AXI-Stream DMA ports,
// the A/B input buffers and the systolic array.
interface systolic_array_sequencer_if;
    logic s_axis_valid;
    logic s_axis_last;
    logic s_axis_ready;
    logic m_axis_valid;
    logic m_axis_last;
    logic m_axis_ready;
    logic buff_is_full;
    logic buff_is_empty;
    logic buff_wr;
    logic buff_rd;
    logic buff_rst_n;
    logic arr_C_valid;
    logic arr_rst_n;

    modport master (
        input  s_axis_valid, s_axis_last, m_axis_ready,
        input  buff_is_full, buff_is_empty, arr_C_valid,
        output s_axis_ready, m_axis_valid, m_axis_last,
        output buff_wr, buff_rd, buff_rst_n, arr_rst_n
    );

    modport slave (
        output s_axis_valid, s_axis_last, m_axis_ready,
        output buff_is_full, buff_is_empty, arr_C_valid,
        input  s_axis_ready, m_axis_valid, m_axis_last,
        input  buff_wr, buff_rd, buff_rst_n, arr_rst_n
    );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Job sequencer for the 3x3 systolic array: CLEAR -> LOAD -> COMPUTE -> DRAIN,
// one job in flight, result handed to the DMA as a single AXIS beat.
module systolic_array_sequencer #(
    parameter int LOAD_BEATS     = 5,
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           axi_clk,
    input  logic                           axi_rst,
    systolic_array_sequencer_if.master     bus,
    output logic                           frame_err,
    output logic                           timeout,
    output logic                           busy,
    output logic [15:0]                    job_cnt
);

    localparam logic [7:0]  BEATS     = 8'(LOAD_BEATS);
    localparam logic [7:0]  BEAT_LAST = 8'(LOAD_BEATS - 1);
    localparam logic [3:0]  CLR_LAST  = 4'(CLR_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  clr_cnt;
    logic [7:0]  beat_cnt;
    logic [7:0]  rd_cnt;
    logic [15:0] to_cnt;
    logic        m_valid;
    logic        m_last;
    logic        buff_clr_n;
    logic        arr_clr_n;
    logic        s_ready;
    logic        beat_acc;
    logic        pop;

    assign s_ready  = (state == LOAD) && !bus.buff_is_full && (beat_cnt < BEATS);
    assign beat_acc = bus.s_axis_valid && s_ready;
    assign pop      = (state == COMPUTE) && (rd_cnt < BEATS) && !bus.buff_is_empty;

    assign bus.s_axis_ready = s_ready;
    assign bus.buff_wr      = beat_acc;
    assign bus.buff_rd      = pop;
    assign bus.m_axis_valid = m_valid;
    assign bus.m_axis_last  = m_last;
    assign bus.buff_rst_n   = buff_clr_n;
    assign bus.arr_rst_n    = arr_clr_n;

    // Clear strobes are registered alongside the state so they stay low for
    // exactly the cycles spent in CLEAR; arr_rst_n stays high in DRAIN so o_C holds.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            beat_cnt   <= '0;
            rd_cnt     <= '0;
            to_cnt     <= '0;
            job_cnt    <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
            buff_clr_n <= 1'b0;
            arr_clr_n  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state      <= LOAD;
                        clr_cnt    <= '0;
                        beat_cnt   <= '0;
                        rd_cnt     <= '0;
                        to_cnt     <= '0;
                        buff_clr_n <= 1'b1;
                        arr_clr_n  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 4'd1;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        busy     <= 1'b1;
                        // An early last drops the partial frame; a missing last only flags it.
                        if (bus.s_axis_last && (beat_cnt < BEAT_LAST)) begin
                            frame_err  <= 1'b1;
                            state      <= CLEAR;
                            clr_cnt    <= '0;
                            buff_clr_n <= 1'b0;
                            arr_clr_n  <= 1'b0;
                        end else if (beat_cnt == BEAT_LAST) begin
                            frame_err <= !bus.s_axis_last;
                            state     <= COMPUTE;
                            rd_cnt    <= '0;
                            to_cnt    <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (pop) begin
                        rd_cnt <= rd_cnt + 8'd1;
                    end
                    to_cnt <= to_cnt + 16'd1;
                    if (bus.arr_C_valid && (rd_cnt == BEATS)) begin
                        state   <= DRAIN;
                        m_valid <= 1'b1;
                        m_last  <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        timeout    <= 1'b1;
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        buff_clr_n <= 1'b0;
                        arr_clr_n  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.m_axis_ready) begin
                        job_cnt    <= job_cnt + 16'd1;
                        m_valid    <= 1'b0;
                        m_last     <= 1'b0;
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        buff_clr_n <= 1'b0;
                        arr_clr_n  <= 1'b0;
                    end
                end
                default: begin
                    state      <= CLEAR;
                    clr_cnt    <= '0;
                    buff_clr_n <= 1'b0;
                    arr_clr_n  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer: nominal job, backpressure, early last,
// timeout, buffer stalls and a mid-job reset, with hand-computed expectations.
module tb_systolic_array_sequencer;

    logic        axi_clk;
    logic        axi_rst;
    logic        frame_err;
    logic        timeout;
    logic        busy;
    logic [15:0] job_cnt;

    int checks   = 0;
    int failures = 0;

    int wr_total  = 0;
    int rd_total  = 0;
    int hs_total  = 0;
    int rdy_drain = 0;

    systolic_array_sequencer_if bus ();

    systolic_array_sequencer #(
        .LOAD_BEATS     (5),
        .CLR_CYCLES     (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .axi_clk   (axi_clk),
        .axi_rst   (axi_rst),
        .bus       (bus),
        .frame_err (frame_err),
        .timeout   (timeout),
        .busy      (busy),
        .job_cnt   (job_cnt)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    // Tallies the per-cycle strobes at the sampling edge.
    always @(negedge axi_clk) begin
        if (bus.buff_wr) wr_total++;
        if (bus.buff_rd) rd_total++;
        if (bus.m_axis_valid && bus.m_axis_ready) hs_total++;
        if (bus.m_axis_valid && bus.s_axis_ready) rdy_drain++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge axi_clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic last, input logic mready,
                                 input logic full, input logic empty, input logic cvalid);
        bus.s_axis_valid  = valid;
        bus.s_axis_last   = last;
        bus.m_axis_ready  = mready;
        bus.buff_is_full  = full;
        bus.buff_is_empty = empty;
        bus.arr_C_valid   = cvalid;
    endtask

    // Starts at posedge+1 in LOAD; ends at posedge+1 after the last accepted beat.
    task automatic send_frame(input int n_beats, input int last_idx, input int full_at);
        int sent = 0;
        int budget = 0;
        int full_left = 0;
        while (sent < n_beats && budget < 200) begin
            bus.buff_is_full = (full_left > 0);
            bus.s_axis_valid = 1'b1;
            bus.s_axis_last  = (sent + 1 == last_idx);
            sample();
            if (full_left > 0) begin
                checkOutput("ready_gated_full", 32'(bus.s_axis_ready), 32'd0);
                full_left--;
            end else if (bus.s_axis_ready) begin
                sent++;
                if (sent == full_at) full_left = 4;
            end
            tick();
            budget++;
        end
        bus.s_axis_valid = 1'b0;
        bus.s_axis_last  = 1'b0;
        bus.buff_is_full = 1'b0;
        checkOutput("frame_beats_sent", 32'(sent), 32'(n_beats));
    endtask

    // Starts at posedge+1 of the first COMPUTE cycle; returns at the negedge
    // where m_axis_valid is first seen, with the COMPUTE cycle index.
    task automatic run_compute(input int cvalid_at, input int empty_at, output int drain_at);
        int k = 0;
        int pops = 0;
        int empty_left = 0;
        bit found = 1'b0;
        drain_at = -1;
        while (!found && k < 200) begin
            bus.arr_C_valid   = (k >= cvalid_at);
            bus.buff_is_empty = (empty_left > 0);
            sample();
            if (bus.m_axis_valid) begin
                drain_at = k;
                found = 1'b1;
            end else begin
                if (empty_left > 0) begin
                    checkOutput("rd_gated_empty", 32'(bus.buff_rd), 32'd0);
                    empty_left--;
                end else if (bus.buff_rd) begin
                    pops++;
                    if (pops == empty_at) empty_left = 3;
                end
                tick();
                k++;
            end
        end
        bus.buff_is_empty = 1'b0;
    endtask

    // Starts at the negedge of the first DRAIN cycle; ends at posedge+1 back in LOAD.
    task automatic drain_phase(input int stall, input int exp_job);
        for (int i = 0; i < stall; i++) begin
            checkOutput("drain_valid_held", 32'(bus.m_axis_valid), 32'd1);
            tick();
            sample();
        end
        checkOutput("drain_valid", 32'(bus.m_axis_valid), 32'd1);
        checkOutput("drain_last", 32'(bus.m_axis_last), 32'd1);
        bus.m_axis_ready = 1'b1;
        tick();
        bus.m_axis_ready = 1'b0;
        bus.arr_C_valid  = 1'b0;
        sample();
        checkOutput("post_hs_valid_low", 32'(bus.m_axis_valid), 32'd0);
        checkOutput("post_hs_job_cnt", 32'(job_cnt), 32'(exp_job));
        checkOutput("clear1_buff_rst_n", 32'(bus.buff_rst_n), 32'd0);
        checkOutput("clear1_arr_rst_n", 32'(bus.arr_rst_n), 32'd0);
        tick();
        sample();
        checkOutput("clear2_buff_rst_n", 32'(bus.buff_rst_n), 32'd0);
        checkOutput("clear2_s_ready", 32'(bus.s_axis_ready), 32'd0);
        tick();
        sample();
        checkOutput("load_buff_rst_n", 32'(bus.buff_rst_n), 32'd1);
        checkOutput("load_arr_rst_n", 32'(bus.arr_rst_n), 32'd1);
        checkOutput("load_s_ready", 32'(bus.s_axis_ready), 32'd1);
        checkOutput("load_busy", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic run_job(input int full_at, input int cvalid_at, input int empty_at,
                           input int stall, input int exp_job);
        int wr0 = wr_total;
        int rd0 = rd_total;
        int hs0 = hs_total;
        int rdy0 = rdy_drain;
        int drain_at;
        send_frame(5, 5, full_at);
        run_compute(cvalid_at, empty_at, drain_at);
        checkOutput("drain_entry_cycle", 32'(drain_at), 32'd9);
        drain_phase(stall, exp_job);
        checkOutput("job_writes", 32'(wr_total - wr0), 32'd5);
        checkOutput("job_pops", 32'(rd_total - rd0), 32'd5);
        checkOutput("job_handshakes", 32'(hs_total - hs0), 32'd1);
        checkOutput("ready_in_drain", 32'(rdy_drain - rdy0), 32'd0);
    endtask

    // Drops reset at posedge+1 and follows CLEAR into LOAD.
    task automatic release_reset();
        tick();
        axi_rst = 1'b0;
        tick();
        sample();
        checkOutput("rel_clear_buff_rst_n", 32'(bus.buff_rst_n), 32'd0);
        checkOutput("rel_clear_s_ready", 32'(bus.s_axis_ready), 32'd0);
        tick();
        sample();
        checkOutput("rel_load_s_ready", 32'(bus.s_axis_ready), 32'd1);
        checkOutput("rel_load_arr_rst_n", 32'(bus.arr_rst_n), 32'd1);
        checkOutput("rel_load_busy", 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        int wr0;
        int rd0;
        int k;
        bit seen;

        axi_rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        sample();
        checkOutput("rst_buff_rst_n", 32'(bus.buff_rst_n), 32'd0);
        checkOutput("rst_arr_rst_n", 32'(bus.arr_rst_n), 32'd0);
        checkOutput("rst_m_valid", 32'(bus.m_axis_valid), 32'd0);
        checkOutput("rst_s_ready", 32'(bus.s_axis_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_job_cnt", 32'(job_cnt), 32'd0);
        release_reset();

        // Nominal job, then the same job under 10 cycles of result backpressure.
        run_job(0, 8, 0, 0, 1);
        run_job(0, 8, 0, 10, 2);

        // Early last on beat 3 drops the frame.
        rd0 = rd_total;
        send_frame(3, 3, 0);
        sample();
        checkOutput("early_frame_err", 32'(frame_err), 32'd1);
        checkOutput("early_buff_rst_n", 32'(bus.buff_rst_n), 32'd0);
        tick();
        sample();
        checkOutput("early_frame_err_pulse", 32'(frame_err), 32'd0);
        checkOutput("early_clear2_s_ready", 32'(bus.s_axis_ready), 32'd0);
        tick();
        sample();
        checkOutput("early_load_s_ready", 32'(bus.s_axis_ready), 32'd1);
        checkOutput("early_load_busy", 32'(busy), 32'd0);
        checkOutput("early_no_pops", 32'(rd_total - rd0), 32'd0);
        checkOutput("early_job_cnt", 32'(job_cnt), 32'd2);
        tick();

        // Frame without last: flagged but computed; array never answers -> timeout.
        wr0 = wr_total;
        rd0 = rd_total;
        send_frame(5, 0, 0);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            sample();
            if (k == 0) checkOutput("missing_last_frame_err", 32'(frame_err), 32'd1);
            if (k == 1) checkOutput("missing_last_pulse", 32'(frame_err), 32'd0);
            if (k == 1) checkOutput("compute_busy", 32'(busy), 32'd1);
            if (timeout) seen = 1'b1;
            else begin
                tick();
                k++;
            end
        end
        checkOutput("timeout_cycle", 32'(k), 32'd64);
        checkOutput("timeout_buff_rst_n", 32'(bus.buff_rst_n), 32'd0);
        checkOutput("timeout_writes", 32'(wr_total - wr0), 32'd5);
        checkOutput("timeout_pops", 32'(rd_total - rd0), 32'd5);
        tick();
        sample();
        checkOutput("timeout_pulse", 32'(timeout), 32'd0);
        tick();
        sample();
        checkOutput("timeout_load_s_ready", 32'(bus.s_axis_ready), 32'd1);
        checkOutput("timeout_job_cnt", 32'(job_cnt), 32'd2);
        tick();
        run_job(0, 8, 0, 0, 3);

        // Buffer full after beat 2, buffer empty after pop 2; array already valid.
        run_job(2, 0, 2, 0, 4);

        // Reset in the middle of COMPUTE.
        send_frame(5, 5, 0);
        tick();
        tick();
        tick();
        axi_rst = 1'b1;
        #1;
        checkOutput("midrst_buff_rst_n", 32'(bus.buff_rst_n), 32'd0);
        checkOutput("midrst_arr_rst_n", 32'(bus.arr_rst_n), 32'd0);
        checkOutput("midrst_job_cnt", 32'(job_cnt), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_buff_rd", 32'(bus.buff_rd), 32'd0);
        checkOutput("midrst_m_valid", 32'(bus.m_axis_valid), 32'd0);
        release_reset();
        run_job(0, 8, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
